// File: rtl/lvds_rx_deframer_if.sv
// Dequeue-side handshake of the LVDS receive deframer.
//   deq_rx     : FIFO head word (driven by the deframer)
//   EN_deq_rx  : head word is consumed on this clock edge (driven by the deframer)
//   RDY_deq_rx : consumer can accept a word (driven by the consumer)
// The master modport is taken by the deframer; the slave modport by the consumer.
interface lvds_rx_deframer_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] deq_rx;
    logic              EN_deq_rx;
    logic              RDY_deq_rx;

    modport master (
        output deq_rx,
        output EN_deq_rx,
        input  RDY_deq_rx
    );

    modport slave (
        input  deq_rx,
        input  EN_deq_rx,
        output RDY_deq_rx
    );
endinterface

// File: rtl/lvds_rx_deframer.sv
// Receive-side framing layer for the LVDS inter-FPGA link.
// Drives the deserialiser bitslip until the training symbol appears, confirms it
// over TRAIN_MATCH consecutive cycles, waits for the start symbol and then
// assembles WORD_SYMS symbols per word (first symbol lands in the MSBs).
// Completed words with MSB set are queued in a DEPTH-entry FIFO and offered on
// the dequeue handshake; words with MSB clear are idle fill and are discarded.
// Ports:
//   rx_inclock    : link receive clock, all logic on posedge
//   reset_n       : asynchronous active-low reset
//   rx_locked     : deserialiser PLL lock; loss of lock returns to IDLE and flushes
//   rx_out        : parallel symbol from the deserialiser, one per cycle
//   realign       : one-cycle retrain request
//   rx_data_align : bitslip request to the deserialiser
//   align_done    : alignment achieved
//   drop_cnt      : saturating count of valid words lost on a full FIFO
//   state_dbg     : FSM state encoding (IDLE=0 .. DATA=4)
//   deq           : dequeue handshake (deq_rx / EN_deq_rx / RDY_deq_rx)
module lvds_rx_deframer #(
    parameter int               SYM_W       = 8,
    parameter int               WORD_SYMS   = 4,
    parameter logic [SYM_W-1:0] TRAIN_SYM   = 8'h6A,
    parameter logic [SYM_W-1:0] START_SYM   = 8'h77,
    parameter int               TRAIN_MATCH = 8,
    parameter int               DEPTH       = 4
) (
    input  logic                 rx_inclock,
    input  logic                 reset_n,
    input  logic                 rx_locked,
    input  logic [SYM_W-1:0]     rx_out,
    input  logic                 realign,
    output logic                 rx_data_align,
    output logic                 align_done,
    output logic [15:0]          drop_cnt,
    output logic [2:0]           state_dbg,
    lvds_rx_deframer_if.master   deq
);
    localparam int WORD_W = SYM_W * WORD_SYMS;
    localparam int IDX_W  = (WORD_SYMS > 1) ? $clog2(WORD_SYMS) : 1;
    localparam int MW     = $clog2(TRAIN_MATCH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HUNT       = 3'd1,
        ST_CONFIRM    = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_DATA       = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic                align_reg, align_next;
    logic                done_reg, done_next;
    logic [MW-1:0]       match_reg, match_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [WORD_W-1:0]   word_reg, word_next;
    logic [WORD_W-1:0]   word_asm;
    logic                push;
    logic                flush;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [WORD_W-1:0]   deq_reg;
    logic [15:0]         drop_reg;
    logic                pop, full, do_write, drop;

    // Word as it stands once the current symbol is written into its slot.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_SYMS; gi++) begin : g_slot
            assign word_asm[WORD_W-1-gi*SYM_W -: SYM_W] =
                (idx_reg == IDX_W'(gi)) ? rx_out : word_reg[WORD_W-1-gi*SYM_W -: SYM_W];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        match_next = match_reg;
        align_next = 1'b0;
        idx_next   = idx_reg;
        word_next  = word_reg;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_locked) state_next = ST_HUNT;
            end
            ST_HUNT: begin
                if (rx_out == TRAIN_SYM) begin
                    // A single required match skips confirmation entirely.
                    if (TRAIN_MATCH == 1) begin
                        state_next = ST_WAIT_START;
                        match_next = '0;
                    end else begin
                        state_next = ST_CONFIRM;
                        match_next = MW'(1);
                    end
                end else begin
                    // Toggling gives one slip request per two cycles so the
                    // deserialiser sees a clean rising edge each time.
                    align_next = ~align_reg;
                end
            end
            ST_CONFIRM: begin
                if (rx_out == TRAIN_SYM) begin
                    if (match_reg + MW'(1) == MW'(TRAIN_MATCH)) begin
                        state_next = ST_WAIT_START;
                        match_next = '0;
                    end else begin
                        match_next = match_reg + MW'(1);
                    end
                end else begin
                    state_next = ST_HUNT;
                    match_next = '0;
                end
            end
            ST_WAIT_START: begin
                if (rx_out == START_SYM) begin
                    state_next = ST_DATA;
                    idx_next   = '0;
                end
            end
            ST_DATA: begin
                word_next = word_asm;
                if (idx_reg == IDX_W'(WORD_SYMS - 1)) begin
                    idx_next = '0;
                    push     = word_asm[WORD_W-1];
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Loss of lock outranks a retrain request.
        if (!rx_locked) begin
            state_next = ST_IDLE;
            match_next = '0;
            align_next = 1'b0;
            idx_next   = '0;
            word_next  = '0;
            push       = 1'b0;
            flush      = 1'b1;
        end else if (realign && state_reg != ST_IDLE) begin
            state_next = ST_HUNT;
            match_next = '0;
            align_next = 1'b0;
            idx_next   = '0;
            word_next  = '0;
            push       = 1'b0;
        end

        done_next = (state_next == ST_WAIT_START) || (state_next == ST_DATA);
    end

    always_ff @(posedge rx_inclock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            align_reg <= 1'b0;
            done_reg  <= 1'b0;
            match_reg <= '0;
            idx_reg   <= '0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            align_reg <= align_next;
            done_reg  <= done_next;
            match_reg <= match_next;
            idx_reg   <= idx_next;
            word_reg  <= word_next;
        end
    end

    // FIFO control. A full FIFO still accepts a push when the head is popped
    // on the same edge.
    always_comb begin
        pop         = (count_reg != '0) && deq.RDY_deq_rx;
        full        = (count_reg == CNT_W'(DEPTH));
        do_write    = push && (!full || pop);
        drop        = push && full && !pop;
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        count_next  = count_reg + CNT_W'(do_write) - CNT_W'(pop);
    end

    always_ff @(posedge rx_inclock) begin
        if (do_write) mem[wr_ptr_reg] <= word_asm;
    end

    always_ff @(posedge rx_inclock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            deq_reg    <= '0;
            drop_reg   <= '0;
        end else begin
            if (drop && drop_reg != 16'hFFFF) drop_reg <= drop_reg + 16'd1;
            if (flush) begin
                // Head register keeps its last value; only occupancy is cleared.
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (do_write) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                rd_ptr_reg <= rd_ptr_next;
                count_reg  <= count_next;
                if (count_next != '0) begin
                    // When nothing older remains, the new head is the word
                    // being written this cycle, which is not yet in mem.
                    if (count_reg - CNT_W'(pop) == '0) deq_reg <= word_asm;
                    else                                deq_reg <= mem[rd_ptr_next];
                end
            end
        end
    end

    assign rx_data_align = align_reg;
    assign align_done    = done_reg;
    assign drop_cnt      = drop_reg;
    assign state_dbg     = state_reg;
    assign deq.deq_rx    = deq_reg;
    assign deq.EN_deq_rx = pop;
endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Directed testbench for lvds_rx_deframer: alignment, word assembly, idle-fill
// discard, FIFO backpressure/drop, confirm failure, lock loss and async reset.
module tb_lvds_rx_deframer;
    logic        rx_inclock = 1'b0;
    logic        reset_n;
    logic        rx_locked;
    logic [7:0]  rx_out;
    logic        realign;
    logic        rx_data_align;
    logic        align_done;
    logic [15:0] drop_cnt;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    lvds_rx_deframer_if #(.WORD_W(32)) deq_if ();

    lvds_rx_deframer dut (
        .rx_inclock    (rx_inclock),
        .reset_n       (reset_n),
        .rx_locked     (rx_locked),
        .rx_out        (rx_out),
        .realign       (realign),
        .rx_data_align (rx_data_align),
        .align_done    (align_done),
        .drop_cnt      (drop_cnt),
        .state_dbg     (state_dbg),
        .deq           (deq_if)
    );

    always #5 rx_inclock = ~rx_inclock;

    task automatic tick();
        @(posedge rx_inclock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int s = 0; s < 4; s++) begin
            rx_out = w[31-8*s -: 8];
            tick();
        end
    endtask

    task automatic train_and_start();
        for (int i = 0; i < 8; i++) begin
            rx_out = 8'h6A;
            tick();
        end
        rx_out = 8'h77;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx_locked = 1'b0; rx_out = 8'h00; realign = 1'b0;
        deq_if.RDY_deq_rx = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({state_dbg, rx_data_align, align_done, drop_cnt, deq_if.EN_deq_rx} !== 22'd0
            || deq_if.deq_rx !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: state=%0d align=%b done=%b drop=%0d en=%b deq=%h, required all zero",
                     state_dbg, rx_data_align, align_done, drop_cnt, deq_if.EN_deq_rx, deq_if.deq_rx);
        end
        $display("reset: state=%0d drop=%0d", state_dbg, drop_cnt);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_alignment();
        rx_locked = 1'b1; rx_out = 8'h35;
        tick();
        n_cmp++;
        if (state_dbg !== 3'd1 || rx_data_align !== 1'b0) begin
            n_bad++;
            $display("FAIL hunt_entry: state=%0d align=%b, required 1/0", state_dbg, rx_data_align);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++;
            if (rx_data_align !== logic'(k % 2)) begin
                n_bad++;
                $display("FAIL bitslip_toggle[%0d]: got %b, required %b", k, rx_data_align, k % 2);
            end
            $display("hunt cycle %0d: rx_data_align=%b", k, rx_data_align);
        end
        for (int k = 1; k <= 8; k++) begin
            rx_out = 8'h6A;
            tick();
            if (k == 1 || k == 7) begin
                n_cmp++;
                if (state_dbg !== 3'd2 || align_done !== 1'b0 || rx_data_align !== 1'b0) begin
                    n_bad++;
                    $display("FAIL confirm[%0d]: state=%0d done=%b align=%b, required 2/0/0",
                             k, state_dbg, align_done, rx_data_align);
                end
            end
        end
        n_cmp++;
        if (state_dbg !== 3'd3 || align_done !== 1'b1) begin
            n_bad++;
            $display("FAIL aligned: state=%0d done=%b, required 3/1", state_dbg, align_done);
        end
        $display("alignment: state=%0d align_done=%b", state_dbg, align_done);
    endtask

    task automatic test_single_word();
        deq_if.RDY_deq_rx = 1'b1;
        rx_out = 8'h77;
        tick();
        n_cmp++;
        if (state_dbg !== 3'd4) begin
            n_bad++;
            $display("FAIL data_entry: state=%0d, required 4", state_dbg);
        end
        send_word(32'h80123456);
        n_cmp++;
        if (deq_if.EN_deq_rx !== 1'b1 || deq_if.deq_rx !== 32'h80123456) begin
            n_bad++;
            $display("FAIL word_out: en=%b deq=%h, required 1/80123456", deq_if.EN_deq_rx, deq_if.deq_rx);
        end
        $display("word: deq_rx=%h EN=%b", deq_if.deq_rx, deq_if.EN_deq_rx);
        rx_out = 8'h00;
        tick();
        n_cmp++;
        if (deq_if.EN_deq_rx !== 1'b0) begin
            n_bad++;
            $display("FAIL en_single_pulse: en=%b, required 0", deq_if.EN_deq_rx);
        end
        repeat (3) tick();
    endtask

    task automatic test_idle_fill();
        logic [31:0] w = 32'h00AABBCC;
        for (int s = 0; s < 4; s++) begin
            rx_out = w[31-8*s -: 8];
            tick();
            n_cmp++;
            if (deq_if.EN_deq_rx !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_fill_en[%0d]: en=%b, required 0", s, deq_if.EN_deq_rx);
            end
        end
        n_cmp++;
        if (drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL idle_fill_drop: drop=%0d, required 0", drop_cnt);
        end
        $display("idle fill: EN=%b drop_cnt=%0d", deq_if.EN_deq_rx, drop_cnt);
    endtask

    task automatic test_backpressure();
        deq_if.RDY_deq_rx = 1'b0;
        for (int i = 0; i < 6; i++) send_word(32'h81000000 + (i << 24) + i);
        n_cmp++;
        if (drop_cnt !== 16'd2 || deq_if.EN_deq_rx !== 1'b0 || deq_if.deq_rx !== 32'h81000000) begin
            n_bad++;
            $display("FAIL full_drop: drop=%0d en=%b deq=%h, required 2/0/81000000",
                     drop_cnt, deq_if.EN_deq_rx, deq_if.deq_rx);
        end
        deq_if.RDY_deq_rx = 1'b1;
        rx_out = 8'h00;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (deq_if.EN_deq_rx !== 1'b1 || deq_if.deq_rx !== 32'h81000000 + (k << 24) + k) begin
                n_bad++;
                $display("FAIL drain[%0d]: en=%b deq=%h, required 1/%h", k, deq_if.EN_deq_rx,
                         deq_if.deq_rx, 32'h81000000 + (k << 24) + k);
            end
            $display("drain %0d: deq_rx=%h EN=%b", k, deq_if.deq_rx, deq_if.EN_deq_rx);
            tick();
        end
        n_cmp++;
        if (deq_if.EN_deq_rx !== 1'b0 || drop_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL drained: en=%b drop=%0d, required 0/2", deq_if.EN_deq_rx, drop_cnt);
        end
    endtask

    task automatic test_confirm_fail();
        realign = 1'b1; rx_out = 8'h00;
        tick();
        realign = 1'b0;
        n_cmp++;
        if (state_dbg !== 3'd1 || align_done !== 1'b0) begin
            n_bad++;
            $display("FAIL realign: state=%0d done=%b, required 1/0", state_dbg, align_done);
        end
        for (int k = 0; k < 5; k++) begin
            rx_out = 8'h6A;
            tick();
        end
        n_cmp++;
        if (state_dbg !== 3'd2 || align_done !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_confirm: state=%0d done=%b, required 2/0", state_dbg, align_done);
        end
        rx_out = 8'h35;
        tick();
        n_cmp++;
        if (state_dbg !== 3'd1 || align_done !== 1'b0) begin
            n_bad++;
            $display("FAIL confirm_abort: state=%0d done=%b, required 1/0", state_dbg, align_done);
        end
        $display("confirm abort: state=%0d align_done=%b", state_dbg, align_done);
    endtask

    task automatic test_lock_loss_and_reset();
        train_and_start();
        deq_if.RDY_deq_rx = 1'b0;
        send_word(32'h90000001);
        send_word(32'h90000002);
        rx_out = 8'hAB; tick();
        rx_out = 8'hCD; tick();
        rx_locked = 1'b0;
        tick();
        deq_if.RDY_deq_rx = 1'b1;
        #1;
        n_cmp++;
        if (state_dbg !== 3'd0 || align_done !== 1'b0 || rx_data_align !== 1'b0
            || deq_if.EN_deq_rx !== 1'b0 || drop_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL lock_loss: state=%0d done=%b align=%b en=%b drop=%0d, required 0/0/0/0/2",
                     state_dbg, align_done, rx_data_align, deq_if.EN_deq_rx, drop_cnt);
        end
        $display("lock loss: state=%0d EN=%b drop_cnt=%0d", state_dbg, deq_if.EN_deq_rx, drop_cnt);
        rx_locked = 1'b1;
        tick();
        train_and_start();
        n_cmp++;
        if (state_dbg !== 3'd4 || align_done !== 1'b1) begin
            n_bad++;
            $display("FAIL relock: state=%0d done=%b, required 4/1", state_dbg, align_done);
        end
        send_word(32'hA5000005);
        rx_out = 8'h91; tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({state_dbg, rx_data_align, align_done, drop_cnt, deq_if.EN_deq_rx} !== 22'd0
            || deq_if.deq_rx !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: state=%0d align=%b done=%b drop=%0d en=%b deq=%h, required all zero",
                     state_dbg, rx_data_align, align_done, drop_cnt, deq_if.EN_deq_rx, deq_if.deq_rx);
        end
        $display("async reset: state=%0d deq_rx=%h drop_cnt=%0d", state_dbg, deq_if.deq_rx, drop_cnt);
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_single_word();
        test_idle_fill();
        test_backpressure();
        test_confirm_fail();
        test_lock_loss_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
